// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the control sequencer: opcodes, state encoding,
// bus-source bit indices, ALU op codes and the bundled strobe word.
package cpu_ctrl_pkg;

  localparam int NUM_REGS = 16;
  localparam int BUS_SRCS = 24;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_JR   = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // T0..T6 encode as their step number so step falls straight out of the state
  localparam logic [3:0] ST_T0   = 4'd0;
  localparam logic [3:0] ST_T1   = 4'd1;
  localparam logic [3:0] ST_T2   = 4'd2;
  localparam logic [3:0] ST_T3   = 4'd3;
  localparam logic [3:0] ST_T4   = 4'd4;
  localparam logic [3:0] ST_T5   = 4'd5;
  localparam logic [3:0] ST_T6   = 4'd6;
  localparam logic [3:0] ST_IDLE = 4'd7;
  localparam logic [3:0] ST_HALT = 4'd8;

  localparam int BUS_HI     = 16;
  localparam int BUS_LO     = 17;
  localparam int BUS_ZHI    = 18;
  localparam int BUS_ZLO    = 19;
  localparam int BUS_PC     = 20;
  localparam int BUS_MDR    = 21;
  localparam int BUS_INPORT = 22;
  localparam int BUS_RAM    = 23;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_MUL = 3'd4;

  typedef struct packed {
    logic [BUS_SRCS-1:0] bus_sel;
    logic [NUM_REGS-1:0] reg_in;
    logic                pc_in;
    logic                ir_in;
    logic                mar_in;
    logic                mdr_in;
    logic                y_in;
    logic                z_in;
    logic                hi_in;
    logic                lo_in;
    logic                outport_in;
    logic                inc_pc;
    logic [2:0]          alu_op;
    logic                mem_read;
    logic                mem_write;
    logic [2:0]          step;
    logic                halted;
    logic                illegal_op;
  } ctrl_t;

  function automatic logic [2:0] alu_code(input logic [4:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_MUL:  return ALU_MUL;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_strobe_decode.sv
// Pure combinational map from (state, ir) to every bus select and load strobe.
// Defaults everything low so each state only names the strobes it raises.
module ctrl_strobe_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0]  state_i,
  input  logic [31:0] ir_i,
  output ctrl_t       ctrl_o
);

  logic [4:0] op;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic       unused_ir;

  assign op        = ir_i[31:27];
  assign ra        = ir_i[26:23];
  assign rb        = ir_i[22:19];
  assign rc        = ir_i[18:15];
  assign unused_ir = ^ir_i[14:0];

  always_comb begin
    ctrl_o      = '0;
    ctrl_o.step = (state_i <= ST_T6) ? state_i[2:0] : 3'd7;
    case (state_i)
      ST_T0: begin
        ctrl_o.bus_sel[BUS_PC] = 1'b1;
        ctrl_o.mar_in          = 1'b1;
        ctrl_o.inc_pc          = 1'b1;
        ctrl_o.z_in            = 1'b1;
      end
      ST_T1: begin
        ctrl_o.bus_sel[BUS_ZLO] = 1'b1;
        ctrl_o.pc_in            = 1'b1;
        ctrl_o.mem_read         = 1'b1;
        ctrl_o.mdr_in           = 1'b1;
      end
      ST_T2: begin
        ctrl_o.bus_sel[BUS_MDR] = 1'b1;
        ctrl_o.ir_in            = 1'b1;
      end
      ST_T3: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            ctrl_o.bus_sel[rb] = 1'b1;
            ctrl_o.y_in        = 1'b1;
          end
          OP_MUL: begin
            ctrl_o.bus_sel[ra] = 1'b1;
            ctrl_o.y_in        = 1'b1;
          end
          OP_LD, OP_ST: begin
            ctrl_o.bus_sel[rb] = 1'b1;
            ctrl_o.mar_in      = 1'b1;
          end
          OP_JR: begin
            ctrl_o.bus_sel[ra] = 1'b1;
            ctrl_o.pc_in       = 1'b1;
          end
          OP_IN: begin
            ctrl_o.bus_sel[BUS_INPORT] = 1'b1;
            ctrl_o.reg_in[ra]          = 1'b1;
          end
          OP_OUT: begin
            ctrl_o.bus_sel[ra] = 1'b1;
            ctrl_o.outport_in  = 1'b1;
          end
          OP_MFHI: begin
            ctrl_o.bus_sel[BUS_HI] = 1'b1;
            ctrl_o.reg_in[ra]      = 1'b1;
          end
          OP_MFLO: begin
            ctrl_o.bus_sel[BUS_LO] = 1'b1;
            ctrl_o.reg_in[ra]      = 1'b1;
          end
          OP_NOP, OP_HALT: ;
          default: ctrl_o.illegal_op = 1'b1;
        endcase
      end
      ST_T4: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            ctrl_o.bus_sel[rc] = 1'b1;
            ctrl_o.alu_op      = alu_code(op);
            ctrl_o.z_in        = 1'b1;
          end
          OP_MUL: begin
            ctrl_o.bus_sel[rb] = 1'b1;
            ctrl_o.alu_op      = ALU_MUL;
            ctrl_o.z_in        = 1'b1;
          end
          OP_LD: begin
            ctrl_o.mem_read = 1'b1;
            ctrl_o.mdr_in   = 1'b1;
          end
          // Store data comes off the bus, so MDR loads without a memory read
          OP_ST: begin
            ctrl_o.bus_sel[ra] = 1'b1;
            ctrl_o.mdr_in      = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            ctrl_o.bus_sel[BUS_ZLO] = 1'b1;
            ctrl_o.reg_in[ra]       = 1'b1;
          end
          OP_MUL: begin
            ctrl_o.bus_sel[BUS_ZLO] = 1'b1;
            ctrl_o.lo_in            = 1'b1;
          end
          OP_LD: begin
            ctrl_o.bus_sel[BUS_MDR] = 1'b1;
            ctrl_o.reg_in[ra]       = 1'b1;
          end
          OP_ST:   ctrl_o.mem_write = 1'b1;
          default: ;
        endcase
      end
      ST_T6: begin
        if (op == OP_MUL) begin
          ctrl_o.bus_sel[BUS_ZHI] = 1'b1;
          ctrl_o.hi_in            = 1'b1;
        end
      end
      ST_HALT: ctrl_o.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control-step sequencer: state register plus next-state logic; all
// strobes come from ctrl_strobe_decode. Memory waits hold T1/T4/T5 indefinitely.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  input  logic [31:0]         ir,
  input  logic                mem_ready,
  output logic [BUS_SRCS-1:0] bus_sel,
  output logic [NUM_REGS-1:0] reg_in,
  output logic                pc_in,
  output logic                ir_in,
  output logic                mar_in,
  output logic                mdr_in,
  output logic                y_in,
  output logic                z_in,
  output logic                hi_in,
  output logic                lo_in,
  output logic                outport_in,
  output logic                inc_pc,
  output logic [2:0]          alu_op,
  output logic                mem_read,
  output logic                mem_write,
  output logic [2:0]          step,
  output logic                halted,
  output logic                illegal_op
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [3:0] done_st;
  logic [4:0] op;
  ctrl_t      ctrl;

  assign op      = ir[31:27];
  assign done_st = run ? ST_T0 : ST_IDLE;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   if (mem_ready) state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_MUL, OP_LD, OP_ST:  state_d = ST_T4;
          OP_HALT:               state_d = ST_HALT;
          default:               state_d = done_st;
        endcase
      end
      ST_T4: begin
        case (op)
          OP_LD: if (mem_ready) state_d = ST_T5;
          OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_MUL, OP_ST:         state_d = ST_T5;
          default:               state_d = done_st;
        endcase
      end
      ST_T5: begin
        case (op)
          OP_MUL:  state_d = ST_T6;
          OP_ST:   if (mem_ready) state_d = done_st;
          default: state_d = done_st;
        endcase
      end
      ST_T6:   state_d = done_st;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  ctrl_strobe_decode u_decode (
    .state_i (state_q),
    .ir_i    (ir),
    .ctrl_o  (ctrl)
  );

  assign bus_sel    = ctrl.bus_sel;
  assign reg_in     = ctrl.reg_in;
  assign pc_in      = ctrl.pc_in;
  assign ir_in      = ctrl.ir_in;
  assign mar_in     = ctrl.mar_in;
  assign mdr_in     = ctrl.mdr_in;
  assign y_in       = ctrl.y_in;
  assign z_in       = ctrl.z_in;
  assign hi_in      = ctrl.hi_in;
  assign lo_in      = ctrl.lo_in;
  assign outport_in = ctrl.outport_in;
  assign inc_pc     = ctrl.inc_pc;
  assign alu_op     = ctrl.alu_op;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign step       = ctrl.step;
  assign halted     = ctrl.halted;
  assign illegal_op = ctrl.illegal_op;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: every observed cycle is compared as one
// packed word {step, bus_sel, reg_in, alu_op, strobes} against hand-built values.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [31:0] ir = '0;
  logic        mem_ready = 1'b0;

  logic [23:0] bus_sel;
  logic [15:0] reg_in;
  logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, outport_in, inc_pc;
  logic [2:0]  alu_op;
  logic        mem_read, mem_write;
  logic [2:0]  step;
  logic        halted, illegal_op;

  int compared   = 0;
  int mismatched = 0;
  logic mon_en = 1'b0;

  always #5 clock = ~clock;

  control_sequencer dut (
    .clock(clock), .reset(reset), .run(run), .ir(ir), .mem_ready(mem_ready),
    .bus_sel(bus_sel), .reg_in(reg_in), .pc_in(pc_in), .ir_in(ir_in),
    .mar_in(mar_in), .mdr_in(mdr_in), .y_in(y_in), .z_in(z_in),
    .hi_in(hi_in), .lo_in(lo_in), .outport_in(outport_in), .inc_pc(inc_pc),
    .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
    .step(step), .halted(halted), .illegal_op(illegal_op)
  );

  localparam logic [13:0] S_PC   = 14'h2000;
  localparam logic [13:0] S_IR   = 14'h1000;
  localparam logic [13:0] S_MAR  = 14'h0800;
  localparam logic [13:0] S_MDR  = 14'h0400;
  localparam logic [13:0] S_Y    = 14'h0200;
  localparam logic [13:0] S_Z    = 14'h0100;
  localparam logic [13:0] S_HI   = 14'h0080;
  localparam logic [13:0] S_LO   = 14'h0040;
  localparam logic [13:0] S_OUT  = 14'h0020;
  localparam logic [13:0] S_INC  = 14'h0010;
  localparam logic [13:0] S_RD   = 14'h0008;
  localparam logic [13:0] S_WR   = 14'h0004;
  localparam logic [13:0] S_HALT = 14'h0002;
  localparam logic [13:0] S_ILL  = 14'h0001;

  logic [59:0] obs;
  assign obs = {step, bus_sel, reg_in, alu_op,
                pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, outport_in,
                inc_pc, mem_read, mem_write, halted, illegal_op};

  function automatic logic [59:0] mk(input logic [2:0] s, input logic [23:0] b,
                                     input logic [15:0] r, input logic [2:0] a,
                                     input logic [13:0] st);
    return {s, b, r, a, st};
  endfunction

  function automatic logic [23:0] b24(input int n);
    return 24'h1 << n;
  endfunction

  function automatic logic [31:0] mkir(input logic [4:0] op, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'h0};
  endfunction

  logic [59:0] E_IDLE, E_T0, E_T1, E_T2;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run = 1'b0;
  endtask

  // Structural invariants on the bus selects, checked every cycle after reset
  always @(negedge clock) begin
    if (mon_en) begin
      compared++;
      if (!$onehot0(bus_sel) || !$onehot0(reg_in) || bus_sel[23] !== 1'b0) begin
        mismatched++;
        $display("FAIL onehot_invariant t=%0t: bus_sel=%h reg_in=%h, required onehot0 and bit23=0",
                 $time, bus_sel, reg_in);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = '0;
    tick(); tick();
    mon_en = 1'b1;
    compared++;
    if (obs !== E_IDLE) begin mismatched++; $display("FAIL reset_state: got %h required %h", obs, E_IDLE); end
    reset = 1'b0; run = 1'b1;
    tick();
    compared++;
    if (obs !== E_T0) begin mismatched++; $display("FAIL reset_t0: got %h required %h", obs, E_T0); end
    tick(); tick();
    compared++;
    if (obs !== E_T1) begin mismatched++; $display("FAIL reset_t1_wait: got %h required %h", obs, E_T1); end
    reset = 1'b1;
    tick();
    compared++;
    if (obs !== E_IDLE) begin mismatched++; $display("FAIL reset_mid_t1: got %h required %h", obs, E_IDLE); end
    reset = 1'b0; run = 1'b0;
    tick();
    compared++;
    if (obs !== E_IDLE) begin mismatched++; $display("FAIL idle_no_run: got %h required %h", obs, E_IDLE); end
  endtask

  task automatic test_add();
    logic [59:0] e [7];
    do_reset();
    ir = mkir(5'b00011, 4'd3, 4'd1, 4'd2);
    run = 1'b1; mem_ready = 1'b1;
    e[0] = E_T0; e[1] = E_T1; e[2] = E_T2;
    e[3] = mk(3'd3, b24(1), 16'h0, 3'd0, S_Y);
    e[4] = mk(3'd4, b24(2), 16'h0, 3'd0, S_Z);
    e[5] = mk(3'd5, b24(19), 16'h0008, 3'd0, 14'h0);
    e[6] = E_T0;
    for (int i = 0; i < 7; i++) begin
      tick();
      compared++;
      if (obs !== e[i]) begin mismatched++; $display("FAIL add_cycle%0d: got %h required %h", i, obs, e[i]); end
    end
  endtask

  task automatic test_alu_ops();
    logic [4:0] ops  [3];
    logic [2:0] alus [3];
    logic [59:0] e4, e5;
    ops[0] = 5'b00100; alus[0] = 3'd1;
    ops[1] = 5'b00101; alus[1] = 3'd2;
    ops[2] = 5'b00110; alus[2] = 3'd3;
    for (int i = 0; i < 3; i++) begin
      do_reset();
      ir = mkir(ops[i], 4'd10, 4'd11, 4'd12);
      run = 1'b1; mem_ready = 1'b1;
      repeat (5) tick();
      e4 = mk(3'd4, b24(12), 16'h0, alus[i], S_Z);
      compared++;
      if (obs !== e4) begin mismatched++; $display("FAIL alu_t4 op%0d: got %h required %h", i, obs, e4); end
      tick();
      e5 = mk(3'd5, b24(19), 16'h0400, 3'd0, 14'h0);
      compared++;
      if (obs !== e5) begin mismatched++; $display("FAIL alu_t5 op%0d: got %h required %h", i, obs, e5); end
    end
  endtask

  task automatic test_fetch_stall();
    do_reset();
    ir = mkir(5'b11010, 4'd0, 4'd0, 4'd0);
    run = 1'b1; mem_ready = 1'b0;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (obs !== E_T1) begin mismatched++; $display("FAIL stall_t1_%0d: got %h required %h", i, obs, E_T1); end
      if (i == 3) mem_ready = 1'b1;
      tick();
    end
    compared++;
    if (obs !== E_T2) begin mismatched++; $display("FAIL stall_t2: got %h required %h", obs, E_T2); end
    tick();
    compared++;
    if (obs !== mk(3'd3, 24'h0, 16'h0, 3'd0, 14'h0)) begin
      mismatched++; $display("FAIL nop_t3: got %h required all-zero step 3", obs);
    end
    run = 1'b0;
    tick();
    compared++;
    if (obs !== E_IDLE) begin mismatched++; $display("FAIL nop_to_idle: got %h required %h", obs, E_IDLE); end
  endtask

  task automatic test_ld_st();
    logic [59:0] e;
    do_reset();
    ir = mkir(5'b00000, 4'd5, 4'd7, 4'd0);
    run = 1'b1; mem_ready = 1'b1;
    repeat (4) tick();
    e = mk(3'd3, b24(7), 16'h0, 3'd0, S_MAR);
    compared++;
    if (obs !== e) begin mismatched++; $display("FAIL ld_t3: got %h required %h", obs, e); end
    mem_ready = 1'b0;
    e = mk(3'd4, 24'h0, 16'h0, 3'd0, S_RD | S_MDR);
    for (int i = 0; i < 2; i++) begin
      tick();
      compared++;
      if (obs !== e) begin mismatched++; $display("FAIL ld_t4_wait%0d: got %h required %h", i, obs, e); end
    end
    mem_ready = 1'b1;
    tick();
    e = mk(3'd5, b24(21), 16'h0020, 3'd0, 14'h0);
    compared++;
    if (obs !== e) begin mismatched++; $display("FAIL ld_t5: got %h required %h", obs, e); end
    ir = mkir(5'b00010, 4'd5, 4'd7, 4'd0);
    tick();
    compared++;
    if (obs !== E_T0) begin mismatched++; $display("FAIL ld_to_t0: got %h required %h", obs, E_T0); end
    repeat (3) tick();
    e = mk(3'd3, b24(7), 16'h0, 3'd0, S_MAR);
    compared++;
    if (obs !== e) begin mismatched++; $display("FAIL st_t3: got %h required %h", obs, e); end
    tick();
    e = mk(3'd4, b24(5), 16'h0, 3'd0, S_MDR);
    compared++;
    if (obs !== e) begin mismatched++; $display("FAIL st_t4: got %h required %h", obs, e); end
    mem_ready = 1'b0;
    e = mk(3'd5, 24'h0, 16'h0, 3'd0, S_WR);
    for (int i = 0; i < 2; i++) begin
      tick();
      compared++;
      if (obs !== e) begin mismatched++; $display("FAIL st_t5_wait%0d: got %h required %h", i, obs, e); end
    end
    mem_ready = 1'b1; run = 1'b0;
    tick();
    compared++;
    if (obs !== E_IDLE) begin mismatched++; $display("FAIL st_to_idle: got %h required %h", obs, E_IDLE); end
  endtask

  task automatic test_mul();
    logic [59:0] e [5];
    do_reset();
    ir = mkir(5'b01111, 4'd4, 4'd6, 4'd0);
    run = 1'b1; mem_ready = 1'b1;
    repeat (4) tick();
    e[0] = mk(3'd3, b24(4), 16'h0, 3'd0, S_Y);
    e[1] = mk(3'd4, b24(6), 16'h0, 3'd4, S_Z);
    e[2] = mk(3'd5, b24(19), 16'h0, 3'd0, S_LO);
    e[3] = mk(3'd6, b24(18), 16'h0, 3'd0, S_HI);
    e[4] = E_T0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      compared++;
      if (obs !== e[i]) begin mismatched++; $display("FAIL mul_cycle%0d: got %h required %h", i, obs, e[i]); end
    end
  endtask

  task automatic test_single_step();
    logic [31:0] irs [6];
    logic [59:0] e   [6];
    irs[0] = mkir(5'b10101, 4'd9, 4'd0, 4'd0);  e[0] = mk(3'd3, b24(9), 16'h0, 3'd0, S_PC);
    irs[1] = mkir(5'b10110, 4'd2, 4'd0, 4'd0);  e[1] = mk(3'd3, b24(22), 16'h0004, 3'd0, 14'h0);
    irs[2] = mkir(5'b10111, 4'd6, 4'd0, 4'd0);  e[2] = mk(3'd3, b24(6), 16'h0, 3'd0, S_OUT);
    irs[3] = mkir(5'b11000, 4'd1, 4'd0, 4'd0);  e[3] = mk(3'd3, b24(16), 16'h0002, 3'd0, 14'h0);
    irs[4] = mkir(5'b11001, 4'd15, 4'd0, 4'd0); e[4] = mk(3'd3, b24(17), 16'h8000, 3'd0, 14'h0);
    irs[5] = mkir(5'b11010, 4'd3, 4'd0, 4'd0);  e[5] = mk(3'd3, 24'h0, 16'h0, 3'd0, 14'h0);
    for (int i = 0; i < 6; i++) begin
      do_reset();
      ir = irs[i]; run = 1'b1; mem_ready = 1'b1;
      repeat (4) tick();
      compared++;
      if (obs !== e[i]) begin mismatched++; $display("FAIL single_t3_%0d: got %h required %h", i, obs, e[i]); end
      run = 1'b0;
      tick();
      compared++;
      if (obs !== E_IDLE) begin mismatched++; $display("FAIL single_idle_%0d: got %h required %h", i, obs, E_IDLE); end
    end
  endtask

  task automatic test_illegal();
    logic [59:0] e;
    e = mk(3'd3, 24'h0, 16'h0, 3'd0, S_ILL);
    do_reset();
    ir = mkir(5'b11111, 4'd0, 4'd0, 4'd0);
    run = 1'b1; mem_ready = 1'b1;
    repeat (4) tick();
    compared++;
    if (obs !== e) begin mismatched++; $display("FAIL illegal_t3: got %h required %h", obs, e); end
    ir = mkir(5'b00001, 4'd2, 4'd3, 4'd4);
    tick();
    compared++;
    if (obs !== E_T0) begin mismatched++; $display("FAIL illegal_pulse_end: got %h required %h", obs, E_T0); end
    repeat (3) tick();
    compared++;
    if (obs !== e) begin mismatched++; $display("FAIL illegal2_t3: got %h required %h", obs, e); end
    run = 1'b0;
    tick();
    compared++;
    if (obs !== E_IDLE) begin mismatched++; $display("FAIL illegal_to_idle: got %h required %h", obs, E_IDLE); end
  endtask

  task automatic test_halt();
    logic [59:0] eh;
    eh = mk(3'd7, 24'h0, 16'h0, 3'd0, S_HALT);
    do_reset();
    ir = mkir(5'b11011, 4'd0, 4'd0, 4'd0);
    run = 1'b1; mem_ready = 1'b1;
    repeat (4) tick();
    compared++;
    if (obs !== mk(3'd3, 24'h0, 16'h0, 3'd0, 14'h0)) begin
      mismatched++; $display("FAIL halt_t3: got %h required all-zero step 3", obs);
    end
    tick();
    compared++;
    if (obs !== eh) begin mismatched++; $display("FAIL halt_enter: got %h required %h", obs, eh); end
    repeat (3) tick();
    compared++;
    if (obs !== eh) begin mismatched++; $display("FAIL halt_sticky: got %h required %h", obs, eh); end
    reset = 1'b1;
    tick();
    reset = 1'b0; run = 1'b0;
    compared++;
    if (obs !== E_IDLE) begin mismatched++; $display("FAIL halt_reset: got %h required %h", obs, E_IDLE); end
  endtask

  initial begin
    E_IDLE = mk(3'd7, 24'h0, 16'h0, 3'd0, 14'h0);
    E_T0   = mk(3'd0, b24(20), 16'h0, 3'd0, S_MAR | S_INC | S_Z);
    E_T1   = mk(3'd1, b24(19), 16'h0, 3'd0, S_PC | S_RD | S_MDR);
    E_T2   = mk(3'd2, b24(21), 16'h0, 3'd0, S_IR);
    test_reset();
    test_add();
    test_alu_ops();
    test_fetch_stall();
    test_ld_st();
    test_mul();
    test_single_step();
    test_illegal();
    test_halt();
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
